ni_packetizer: RTL

// Local-port transmitter of the network interface. Turns a core send request
// (destination address + payload words) into a flit stream for the router's

---
 rtl/ni_packetizer_if.sv | 26 ++
 rtl/ni_packetizer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ni_packetizer_if.sv
// Core-to-packetizer request/payload handshake and packetizer-to-router flit/credit link.
// The master side is the core/router environment; the slave side is the packetizer.
interface ni_packetizer_if;
  logic        pkt_req;
  logic [7:0]  pkt_dest;
  logic [7:0]  pkt_len;
  logic        pkt_ack;
  logic        pkt_err;
  logic [28:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] flit_out;
  logic        flit_valid;
  logic        credit_in;
  logic        busy;

  modport master (
    output pkt_req, pkt_dest, pkt_len, data_in, data_valid, credit_in,
    input  pkt_ack, pkt_err, data_ready, flit_out, flit_valid, busy
  );

  modport slave (
    input  pkt_req, pkt_dest, pkt_len, data_in, data_valid, credit_in,
    output pkt_ack, pkt_err, data_ready, flit_out, flit_valid, busy
  );
endinterface

// File: rtl/ni_packetizer.sv
// Network-interface local-port transmitter: turns a core send request into a header flit
// plus body flits, flow-controlled by credits against the router's local input buffer.
module ni_packetizer #(
  parameter int unsigned CREDIT_DEPTH = 4,
  parameter int unsigned MAX_LEN      = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     current_address,
  ni_packetizer_if.slave bus_io
);

  localparam int unsigned CreditW = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CreditW-1:0] CreditMax = CreditW'(CREDIT_DEPTH);

  typedef enum logic [1:0] {StIdle, StHeader, StBody} state_e;

  state_e               state_q, state_d;
  logic [CreditW-1:0]   credits_q, credits_d;
  logic [7:0]           dest_q, dest_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           remain_q, remain_d;
  logic [31:0]          flit_q, flit_d;
  logic                 flit_valid_q, flit_valid_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 has_credit;
  logic                 send;
  logic                 len_ok;

  always_comb begin
    has_credit   = (credits_q != '0);
    len_ok       = (bus_io.pkt_len != 8'd0) && (32'(bus_io.pkt_len) <= MAX_LEN);
    state_d      = state_q;
    credits_d    = credits_q;
    dest_d       = dest_q;
    len_d        = len_q;
    remain_d     = remain_q;
    flit_d       = flit_q;
    flit_valid_d = 1'b0;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    send         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.pkt_req) begin
          if (len_ok) begin
            dest_d   = bus_io.pkt_dest;
            len_d    = bus_io.pkt_len;
            remain_d = bus_io.pkt_len;
            ack_d    = 1'b1;
            state_d  = StHeader;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StHeader: begin
        if (has_credit) begin
          flit_d       = {3'b001, 5'b0, len_q, current_address, dest_q};
          flit_valid_d = 1'b1;
          send         = 1'b1;
          state_d      = StBody;
        end
      end
      StBody: begin
        if (bus_io.data_valid && has_credit) begin
          flit_d       = {1'b0, (remain_q == 8'd1), 1'b0, bus_io.data_in};
          flit_valid_d = 1'b1;
          send         = 1'b1;
          remain_d     = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A send and a returned credit in the same cycle cancel out.
    if (send && !bus_io.credit_in) begin
      credits_d = credits_q - CreditW'(1);
    end else if (!send && bus_io.credit_in && (credits_q != CreditMax)) begin
      credits_d = credits_q + CreditW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      credits_q    <= CreditMax;
      dest_q       <= 8'd0;
      len_q        <= 8'd0;
      remain_q     <= 8'd0;
      flit_q       <= 32'd0;
      flit_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      dest_q       <= dest_d;
      len_q        <= len_d;
      remain_q     <= remain_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign bus_io.flit_out   = flit_q;
  assign bus_io.flit_valid = flit_valid_q;
  assign bus_io.pkt_ack    = ack_q;
  assign bus_io.pkt_err    = err_q;
  assign bus_io.data_ready = (state_q == StBody) && has_credit;
  assign bus_io.busy       = (state_q != StIdle);

endmodule
